// File: rtl/alu_sched_pkg.sv
// Shared opcode codes and sequencer state encoding for the ALU scheduler and its peers.
package alu_sched_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_SLT  = 4'd7,
    OP_LSL  = 4'd8,
    OP_LSR  = 4'd9,
    OP_LDR  = 4'd10,
    OP_STR  = 4'd11,
    OP_BEQ  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response/ALU-drive bundle of the ALU scheduler; slave = scheduler, master = requesters + ALU.
interface alu_sched_if #(
  parameter int W   = 16,
  parameter int OPW = 4
);
  logic           req0_valid, req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a, req1_b;

  logic           rsp0_valid, rsp0_ready, rsp0_zero;
  logic [W-1:0]   rsp0_out;
  logic           rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0]   rsp1_out;

  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic           alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_out, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_out, rsp0_zero,
    output rsp1_valid, rsp1_out, rsp1_zero,
    output alu_op, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_out, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_zero,
    input  rsp1_valid, rsp1_out, rsp1_zero,
    input  alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_sched_arb2.sv
// Combinational 2-way grant; ALU_SCHED_RR_EN selects round-robin ties, otherwise port 0 has fixed priority.
module alu_sched_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic g0,
  output logic g1
);

`ifdef ALU_SCHED_RR_EN
  // On a tie the port that did not win last time goes next.
  assign g0 = v0 & (~v1 | last);
  assign g1 = v1 & (~v0 | ~last);
`else
  logic unused_last;
  assign unused_last = last;
  assign g0 = v0;
  assign g1 = v1 & ~v0;
`endif

endmodule

// File: rtl/alu_sched.sv
// Time-shares one combinational ALU between two requesters; accept edge N -> rsp_valid in cycle N+2.
// New requests are accepted only in IDLE or in the owner's response handshake cycle (ALU_SCHED_RR_EN: round-robin ties).
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int W   = 16,
  parameter int OPW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  io
);

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic           zero_q, zero_d;

  logic g0, g1, rsp_hs, win, acc0, acc1, rsp0_vld, rsp1_vld;

  alu_sched_arb2 u_arb2 (
    .v0   (io.req0_valid),
    .v1   (io.req1_valid),
    .last (last_q),
    .g0   (g0),
    .g1   (g1)
  );

  always_comb begin
    rsp0_vld = (state_q == RESP) & ~owner_q;
    rsp1_vld = (state_q == RESP) &  owner_q;
    rsp_hs   = (rsp0_vld & io.rsp0_ready) | (rsp1_vld & io.rsp1_ready);
    // Gated by rst_n so no request is acknowledged while reset is held.
    win      = rst_n & ((state_q == IDLE) | rsp_hs);
    acc0     = win & g0;
    acc1     = win & g1;

    io.req0_ready = acc0;
    io.req1_ready = acc1;
    io.rsp0_valid = rsp0_vld;
    io.rsp1_valid = rsp1_vld;
    io.rsp0_out   = rsp0_vld ? res_q : '0;
    io.rsp0_zero  = rsp0_vld & zero_q;
    io.rsp1_out   = rsp1_vld ? res_q : '0;
    io.rsp1_zero  = rsp1_vld & zero_q;
    io.alu_op     = op_q;
    io.alu_a      = a_q;
    io.alu_b      = b_q;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;

    if (acc0 | acc1) begin
      owner_d = acc1;
      last_d  = acc1;
      op_d    = acc1 ? io.req1_op : io.req0_op;
      a_d     = acc1 ? io.req1_a  : io.req0_a;
      b_d     = acc1 ? io.req1_b  : io.req0_b;
    end

    case (state_q)
      IDLE: if (acc0 | acc1) state_d = EXEC;
      EXEC: begin
        res_d   = io.alu_out;
        zero_d  = io.alu_zero;
        state_d = RESP;
      end
      RESP: if (rsp_hs) state_d = (acc0 | acc1) ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: behavioural ALU, scoreboard of expected responses keyed by port.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int W   = 16;
  localparam int OPW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sched_if #(.W(W), .OPW(OPW)) io ();

  alu_sched #(.W(W), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD, OP_ADDI, OP_LDR, OP_STR: return a + b;
      OP_SUB, OP_BEQ:                  return a - b;
      OP_AND:                          return a & b;
      OP_OR:                           return a | b;
      OP_XOR:                          return a ^ b;
      OP_NOT:                          return ~a;
      OP_SLT:                          return {15'd0, ($signed(a) < $signed(b))};
      OP_LSL:                          return a << b[3:0];
      OP_LSR:                          return a >> b[3:0];
      default:                         return 16'hDEAD;
    endcase
  endfunction

  always_comb begin
    io.alu_out  = alu_f(io.alu_op, io.alu_a, io.alu_b);
    io.alu_zero = (alu_f(io.alu_op, io.alu_a, io.alu_b) == 16'd0);
  end

  typedef struct packed {
    logic        port;
    logic [15:0] out;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          acc_log[$];
  int          acc_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [1:0]  acc_now = '0, hs_now = '0, pv = '0, phs = '0, seen_rsp = '0;
  logic [1:0]  s_rdy = '0, s_rv = '0;
  logic [15:0] s_out1 = '0;
  logic [15:0] last_out [2];
  logic        last_zero [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic vld, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin
      io.req0_valid = vld; io.req0_op = op; io.req0_a = a; io.req0_b = b;
    end else begin
      io.req1_valid = vld; io.req1_op = op; io.req1_a = a; io.req1_b = b;
    end
  endtask

  task automatic drive_rand(input int p);
    drive(p, 1'b1, 4'($urandom_range(0, 12)), 16'($urandom), 16'($urandom));
  endtask

  // One clock: sample at the falling edge, score, then return 1 time unit after the rising edge.
  task automatic cyc();
    logic [1:0]  v, rdy, rv, rr;
    logic [15:0] ro [2];
    logic        rz [2];
    logic [3:0]  op [2];
    logic [15:0] a [2], b [2];
    int          idx[$];
    exp_t        e;
    @(negedge clk);
    v   = {io.req1_valid, io.req0_valid};
    rdy = {io.req1_ready, io.req0_ready};
    rv  = {io.rsp1_valid, io.rsp0_valid};
    rr  = {io.rsp1_ready, io.rsp0_ready};
    ro[0] = io.rsp0_out;  rz[0] = io.rsp0_zero; ro[1] = io.rsp1_out; rz[1] = io.rsp1_zero;
    op[0] = io.req0_op;   a[0] = io.req0_a;     b[0] = io.req0_b;
    op[1] = io.req1_op;   a[1] = io.req1_a;     b[1] = io.req1_b;
    check("one_ready", 64'(rdy[0] & rdy[1]), 64'd0);
    check("one_rsp_valid", 64'(rv[0] & rv[1]), 64'd0);
    for (int p = 0; p < 2; p++) begin
      if (rv[p]) begin
        idx = sb.find_first_index(x) with (x.port == p[0]);
        if (idx.size() == 0) check($sformatf("rsp%0d_unexpected", p), 64'(rv[p]), 64'd0);
        else begin
          e = sb[idx[0]];
          if (!pv[p] || phs[p]) check($sformatf("rsp%0d_latency", p), 64'(cycle - e.cyc), 64'd2);
          if (rr[p]) begin
            check($sformatf("rsp%0d_out", p), 64'(ro[p]), 64'(e.out));
            check($sformatf("rsp%0d_zero", p), 64'(rz[p]), 64'(e.zero));
            last_out[p]  = ro[p];
            last_zero[p] = rz[p];
            sb.delete(idx[0]);
          end
        end
      end else begin
        check($sformatf("rsp%0d_quiet", p), 64'({ro[p], rz[p]}), 64'd0);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (v[p] & rdy[p]) begin
        sb.push_back('{port: p[0], out: alu_f(op[p], a[p], b[p]),
                       zero: (alu_f(op[p], a[p], b[p]) == 16'd0), cyc: cycle});
        acc_log.push_back(p);
        acc_cyc.push_back(cycle);
      end
    end
    acc_now  = v & rdy;
    hs_now   = rv & rr;
    pv       = rv;
    phs      = rv & rr;
    seen_rsp = seen_rsp | rv;
    s_rdy    = rdy;
    s_rv     = rv;
    s_out1   = ro[1];
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send(input int p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    drive(p, 1'b1, op, a, b);
    do begin cyc(); n++; end while (!acc_now[p] && n < 20);
    check($sformatf("req%0d_accept", p), 64'(acc_now[p]), 64'd1);
    drive(p, 1'b0, op, a, b);
  endtask

  task automatic wait_rsp(input int p);
    int n = 0;
    do begin cyc(); n++; end while (!hs_now[p] && n < 20);
    check($sformatf("rsp%0d_arrive", p), 64'(hs_now[p]), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin cyc(); n++; end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 4'd0, 16'd0, 16'd0);
    io.rsp0_ready = 1'b1;
    io.rsp1_ready = 1'b1;
    last_out[0] = '0; last_out[1] = '0; last_zero[0] = 1'b0; last_zero[1] = 1'b0;

    // Reset state, with both requesters already asserting valid.
    repeat (2) @(posedge clk);
    #1;
    io.req0_valid = 1'b1;
    io.req1_valid = 1'b1;
    #1;
    check("rst_ready", 64'({io.req1_ready, io.req0_ready}), 64'd0);
    check("rst_rsp_valid", 64'({io.rsp1_valid, io.rsp0_valid}), 64'd0);
    check("rst_rsp_out", 64'({io.rsp0_out, io.rsp0_zero, io.rsp1_out, io.rsp1_zero}), 64'd0);
    check("rst_alu_drive", 64'({io.alu_op, io.alu_a, io.alu_b}), 64'd0);
    io.req0_valid = 1'b0;
    io.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single operations on port 0.
    seen_rsp = '0;
    send(0, OP_ADD, 16'h0003, 16'h0004);
    wait_rsp(0);
    check("add_out", 64'(last_out[0]), 64'h0007);
    check("add_zero", 64'(last_zero[0]), 64'd0);
    check("add_no_rsp1", 64'(seen_rsp[1]), 64'd0);
    send(0, OP_SUB, 16'h0005, 16'h0005);
    wait_rsp(0);
    check("sub_out", 64'(last_out[0]), 64'h0000);
    check("sub_zero", 64'(last_zero[0]), 64'd1);

    // Continuous demand on both ports with responses always taken.
    acc_log.delete();
    acc_cyc.delete();
    drive_rand(0);
    drive_rand(1);
    n = 0;
    while (acc_log.size() < 8 && n < 60) begin
      cyc();
      n++;
      if (acc_now[0]) drive_rand(0);
      if (acc_now[1]) drive_rand(1);
    end
    check("tp_count", 64'(acc_log.size()), 64'd8);
    for (int i = 0; i < acc_log.size(); i++) begin
      if (i > 0) check("tp_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);
`ifdef ALU_SCHED_RR_EN
      check("rr_order", 64'(acc_log[i]), 64'((i % 2 == 0) ? 1 : 0));
`else
      check("fixed_order", 64'(acc_log[i]), 64'd0);
`endif
    end
    cyc();
    io.req0_valid = 1'b0;
    cyc();
    check("drop0_acc1", 64'(acc_now[1]), 64'd1);
    io.req1_valid = 1'b0;
    drain();

    // Port 1 response held back while port 0 waits.
    io.rsp1_ready = 1'b0;
    send(1, OP_XOR, 16'h00FF, 16'h0F0F);
    n = 0;
    do begin cyc(); n++; end while (!s_rv[1] && n < 20);
    check("bp_rsp1_up", 64'(s_rv[1]), 64'd1);
    drive(0, 1'b1, OP_OR, 16'h1200, 16'h0034);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_no_rdy0", 64'(s_rdy[0]), 64'd0);
      check("bp_rsp1_hold", 64'({s_rv[1], s_out1}), 64'({1'b1, 16'h0FF0}));
    end
    io.rsp1_ready = 1'b1;
    cyc();
    check("bp_acc0_on_hs", 64'({acc_now[0], hs_now[1]}), 64'b11);
    drive(0, 1'b0, OP_OR, 16'h1200, 16'h0034);
    wait_rsp(0);
    check("bp_or_out", 64'(last_out[0]), 64'h1234);

    // Reset while an op is in EXEC.
    drive(0, 1'b1, OP_AND, 16'hF0F0, 16'h0FF0);
    n = 0;
    do begin cyc(); n++; end while (!acc_now[0] && n < 20);
    drive(1, 1'b1, OP_ADD, 16'h0001, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'({io.req1_ready, io.req0_ready}), 64'd0);
    check("arst_rsp_valid", 64'({io.rsp1_valid, io.rsp0_valid}), 64'd0);
    check("arst_alu_drive", 64'({io.alu_op, io.alu_a, io.alu_b}), 64'd0);
    sb.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check("arst_no_stale", 64'(s_rv), 64'd0);
    check("arst_tie_winner", 64'(acc_now), 64'b01);
    drive(0, 1'b0, OP_AND, 16'hF0F0, 16'h0FF0);
    n = 0;
    do begin cyc(); n++; end while (!acc_now[1] && n < 20);
    check("arst_and_out", 64'(last_out[0]), 64'h00F0);
    drive(1, 1'b0, OP_ADD, 16'h0001, 16'h0001);
    drain();
    check("arst_add_out", 64'(last_out[1]), 64'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
